// File: rtl/conv_cfg_pkg.sv
// Shared convolution geometry: scheduler states, dimension helpers and widths.
// Imported by the scheduler, MAC controller and RAM wrappers.
package conv_cfg_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

  function automatic int out_dim(input int img, input int k, input int s);
    return (img - k) / s + 1;
  endfunction

  function automatic int row_step(input int img_w, input int s);
    return s * img_w;
  endfunction

  // Width of an index that must reach n-1; never zero.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IMG_W    = 28;
  localparam int IMG_H    = 28;
  localparam int K        = 3;
  localparam int STRIDE   = 1;
  localparam int NUM_FILT = 4;
  localparam int OUT_W    = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H    = out_dim(IMG_H, K, STRIDE);
  localparam int ROW_W    = cw(OUT_H);
  localparam int COL_W    = cw(OUT_W);
  localparam int FILT_W   = cw(NUM_FILT);

endpackage

// File: rtl/conv_patch_scheduler_wrap_counter.sv
// Modulo-(MAX+1) counter; wrap fires on the increment that returns to 0.
// Chained through wrap to build the col/row/filter walk.
import conv_cfg_pkg::*;

module wrap_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic             wrap,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  logic [WIDTH-1:0] r_value;
  logic             w_at_last;

  assign w_at_last = (r_value == LAST);
  assign wrap      = inc & w_at_last;
  assign value     = r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc) begin
      r_value <= w_at_last ? '0 : r_value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/conv_patch_scheduler.sv
// Patch walker: steps col/row/filter per advance and tracks image/output addresses.
// Holds done high after the final patch until the next start.
import conv_cfg_pkg::*;

module conv_patch_scheduler #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 3,
  parameter int STRIDE     = 1,
  parameter int NUM_FILT   = 4,
  parameter int ADDR_W     = 10,
  parameter int OUT_ADDR_W = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic advance,
  output logic busy,
  output logic done,
  output logic done_pulse,
  output logic [cw(out_dim(IMG_H, K, STRIDE))-1:0] patch_row,
  output logic [cw(out_dim(IMG_W, K, STRIDE))-1:0] patch_col,
  output logic [cw(NUM_FILT)-1:0]                  filt_idx,
  output logic [ADDR_W-1:0]                        in_base_addr,
  output logic [OUT_ADDR_W-1:0]                    out_addr
);

  localparam int OW = out_dim(IMG_W, K, STRIDE);
  localparam int OH = out_dim(IMG_H, K, STRIDE);
  localparam int RW = cw(OH);
  localparam int CW = cw(OW);
  localparam int FW = cw(NUM_FILT);

  localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ROW_INC  = ADDR_W'(row_step(IMG_W, STRIDE));

  sched_state_t r_state;
  sched_state_t w_next;

  logic                  w_run;
  logic                  w_adv;
  logic                  w_clr;
  logic                  w_col_wrap;
  logic                  w_row_wrap;
  logic                  w_last;
  logic [ADDR_W-1:0]     r_row_base;
  logic [ADDR_W-1:0]     r_in_base;
  logic [OUT_ADDR_W-1:0] r_out_addr;
  logic                  r_done_pulse;

  assign w_run = (r_state == S_RUN);
  assign w_adv = w_run & advance;
  assign w_clr = ~w_run & start;

  wrap_counter #(.WIDTH(CW), .MAX(OW - 1)) u_col (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_adv),
    .wrap  (w_col_wrap),
    .value (patch_col)
  );

  wrap_counter #(.WIDTH(RW), .MAX(OH - 1)) u_row (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_col_wrap),
    .wrap  (w_row_wrap),
    .value (patch_row)
  );

  wrap_counter #(.WIDTH(FW), .MAX(NUM_FILT - 1)) u_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_row_wrap),
    .wrap  (w_last),
    .value (filt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RUN;
      S_RUN:  if (w_last) w_next = S_DONE;
      S_DONE: if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Incremental window base: no multiplier on the address path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_base   <= '0;
      r_in_base    <= '0;
      r_out_addr   <= '0;
      r_done_pulse <= 1'b0;
    end else begin
      r_done_pulse <= w_last;
      if (w_clr) begin
        r_row_base <= '0;
        r_in_base  <= '0;
        r_out_addr <= '0;
      end else if (w_adv) begin
        r_out_addr <= w_last ? '0 : r_out_addr + OUT_ADDR_W'(1);
        if (w_row_wrap) begin
          r_row_base <= '0;
          r_in_base  <= '0;
        end else if (w_col_wrap) begin
          r_row_base <= r_row_base + ROW_INC;
          r_in_base  <= r_row_base + ROW_INC;
        end else begin
          r_in_base <= r_in_base + COL_STEP;
        end
      end
    end
  end

  assign busy         = w_run;
  assign done         = (r_state == S_DONE);
  assign done_pulse   = r_done_pulse;
  assign in_base_addr = r_in_base;
  assign out_addr     = r_out_addr;

endmodule
